button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Collects single-cycle press pulses from N debounced push buttons and serialises them into one event stream with a valid/ready handshake. Each button has a one-deep pending flag, so a press is never lost while the consumer is busy. Grants are round-robin, so no button can starve another. Sits between the per-button debouncers and the system controller FSM, which consumes one button event at a time.

## Interface
- `N_BUTTONS`, 4: number of button inputs; legal range 2..16.
- `IDX_W`, `$clog2(N_BUTTONS)`: width of the event index; derived, do not override.

- `clk` input 1: single system clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pb_pulse` input N_BUTTONS: debounced one-cycle press pulses; bit i high for exactly one cycle per press.
- `evt_valid` output 1: an event is presented on `evt_id`.
- `evt_ready` input 1: consumer accepts the event in this cycle.
- `evt_id` output IDX_W: index of the button whose press is presented.
- `overrun` output N_BUTTONS: sticky per button; a press arrived while that button's previous press was still pending.
- `overrun_clr` input 1: clears all `overrun` bits.

## Operation
- State: `pending[N-1:0]`, output register (`evt_valid`, `evt_id`), round-robin pointer `ptr[IDX_W-1:0]`, `overrun[N-1:0]`.
- Output FSM has two states. EMPTY means `evt_valid`=0. FULL means `evt_valid`=1.
- Load condition: `load` = EMPTY, or FULL with `evt_ready`=1.
- Pending set: `pb_pulse[i]`=1 sets `pending[i]` on the next edge.
- Grant: on `load` with any `pending` bit set, select the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. Then:
  - `evt_id` takes the selected index.
  - `evt_valid` becomes 1.
  - `pending[sel]` clears.
  - `ptr` becomes (sel+1) mod N_BUTTONS. The wrap from N-1 goes to 0; for non-power-of-2 N, the pointer never takes illegal values.
- On `load` with no `pending` bit set, `evt_valid` goes to 0 (FULL→EMPTY after a handshake). `evt_id` holds its last value.
- Stability: while FULL and `evt_ready`=0, `evt_valid` and `evt_id` do not change.
- Same-bit collision: `pb_pulse[i]` in the same cycle that `pending[i]` is granted leaves `pending[i]`=1 (a new press). No overrun is flagged.
- Overrun: `pb_pulse[i]` while `pending[i]`=1 and i is not granted in that cycle:
  - `overrun[i]` is set.
  - The pulse is merged into the existing pending press, so only one event is delivered.
- `pending` only records presses. Only the selected bit is granted per cycle; all other pulses are captured concurrently.
- `overrun_clr`: clears all `overrun` bits on the next edge. A new overrun in the same cycle wins, so that bit stays 1.
- `evt_ready` while EMPTY is ignored.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `pending` = 0, `evt_valid` = 0, `evt_id` = 0, `ptr` = 0, `overrun` = 0.
  - All pulses during reset are discarded.
- Reset mid-operation: any presented or pending events are dropped; no partial handshake survives.
- Latency with the output EMPTY: pulse at edge t → `pending` at t+1 → `evt_valid`=1 after edge t+2.
- Throughput: one event per cycle while `evt_ready` is held at 1 and presses are pending.
- Handshake completes on an edge where `evt_valid`=1 and `evt_ready`=1. The next pending event is presented in the following cycle with no bubble.
- `evt_valid` may fall only after a completed handshake.

## Test plan
- Reset, then `pb_pulse`=4'b0100 for one cycle with `evt_ready`=0:
  - `evt_valid`=1 and `evt_id`=2 two cycles after the pulse.
  - Both hold for 10 cycles.
  - After `evt_ready`=1 for one cycle, `evt_valid`=0.
- `pb_pulse`=4'b1111 in one cycle, `evt_ready`=1 held:
  - Events on consecutive cycles with `evt_id` = 0, 1, 2, 3.
  - Then `evt_valid`=0 and `overrun`=0.
- Fairness:
  - Grant button 3 first, so `ptr` wraps to 0.
  - Then pend buttons 1 and 3 together: `evt_id`=1 then 3.
  - Then pend 0 and 3: `evt_id`=3 is not granted before 0; order is 0, 3.
- Overrun: with `evt_ready`=0, pulse button 1 twice, 5 cycles apart:
  - `overrun`=4'b0010.
  - Exactly one event with `evt_id`=1 on release.
  - `overrun_clr` pulse gives `overrun`=0 next cycle.
- Collision: pulse button 0 in the cycle its pending press is granted:
  - Two events with `evt_id`=0 are delivered.
  - `overrun[0]` stays 0.
- Assert `rst` mid-stream with `evt_valid`=1 and 3 presses pending:
  - All outputs are 0 immediately.
  - No events appear after release until new pulses arrive.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that serialises one-cycle button press pulses into a
// single valid/ready event stream, with one pending press held per button.
module button_event_arbiter #(
    parameter  int N_BUTTONS = 4,
    localparam int IDX_W     = $clog2(N_BUTTONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] pb_pulse,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [IDX_W-1:0]     evt_id,
    output logic [N_BUTTONS-1:0] overrun,
    input  logic                 overrun_clr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [N_BUTTONS-1:0]   pending_q, pending_d;
    logic [N_BUTTONS-1:0]   overrun_q, overrun_d;
    logic [IDX_W-1:0]       evt_id_q, evt_id_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic                   load_s;
    logic [IDX_W:0]         pick_s;
    logic [IDX_W-1:0]       sel_s;
    logic [N_BUTTONS-1:0]   grant_mask_s;

    // Returns {found, index} of the first request at or after ptr, wrapping.
    // Scanning from the far end lets the candidate nearest ptr overwrite the rest.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_BUTTONS-1:0] req,
                                               input logic [IDX_W-1:0]     ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = N_BUTTONS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_BUTTONS) begin
                idx = idx - N_BUTTONS;
            end else begin
                idx = idx;
            end
            if (req[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        ptr_d        = ptr_q;
        grant_mask_s = '0;
        pick_s       = rr_pick(pending_q, ptr_q);
        sel_s        = pick_s[IDX_W-1:0];

        case (state_q)
            EMPTY:   load_s = 1'b1;
            FULL:    load_s = evt_ready;
            default: load_s = 1'b1;
        endcase

        if (load_s) begin
            if (pick_s[IDX_W]) begin
                state_d      = FULL;
                evt_id_d     = sel_s;
                grant_mask_s = {{(N_BUTTONS-1){1'b0}}, 1'b1} << sel_s;
                ptr_d        = (sel_s == IDX_W'(N_BUTTONS - 1)) ? '0 : sel_s + IDX_W'(1);
            end else begin
                state_d = EMPTY;
            end
        end else begin
            state_d = state_q;
        end

        // A pulse on the bit being granted is a fresh press, not an overrun.
        pending_d = (pending_q & ~grant_mask_s) | pb_pulse;
        overrun_d = (overrun_clr ? '0 : overrun_q) | (pb_pulse & pending_q & ~grant_mask_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            pending_q <= '0;
            overrun_q <= '0;
            evt_id_q  <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            evt_id_q  <= evt_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign evt_valid = (state_q == FULL);
    assign evt_id    = evt_id_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: a per-cycle reference model of the
// arbitration rules plus literal expectations for each scenario.
module tb_button_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] pb_pulse = '0;
    logic         evt_valid;
    logic         evt_ready = 1'b0;
    logic [1:0]   evt_id;
    logic [N-1:0] overrun;
    logic         overrun_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_pend [N];
    bit m_ovr  [N];
    bit m_valid = 1'b0;
    int m_id    = 0;
    int m_ptr   = 0;

    int dut_log [$];

    button_event_arbiter #(.N_BUTTONS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .pb_pulse    (pb_pulse),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model_ovr_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_ovr[i];
        return v;
    endfunction

    // Model: applies the arbitration rules at every rising edge from the inputs seen there.
    initial begin
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_ovr[i]  = 1'b0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    m_pend[i] = 1'b0;
                    m_ovr[i]  = 1'b0;
                end
                m_valid = 1'b0;
                m_id    = 0;
                m_ptr   = 0;
            end else begin
                bit load;
                int sel;
                load = !m_valid || evt_ready;
                sel  = -1;
                if (load) begin
                    for (int k = 0; k < N; k++) begin
                        if (sel < 0 && m_pend[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
                    end
                end
                if (overrun_clr) begin
                    for (int i = 0; i < N; i++) m_ovr[i] = 1'b0;
                end
                for (int i = 0; i < N; i++) begin
                    bit granted;
                    granted = (sel == i);
                    if (pb_pulse[i] && m_pend[i] && !granted) m_ovr[i] = 1'b1;
                    m_pend[i] = (m_pend[i] && !granted) || pb_pulse[i];
                end
                if (load) begin
                    if (sel >= 0) begin
                        m_valid = 1'b1;
                        m_id    = sel;
                        m_ptr   = (sel + 1) % N;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge; also log handshakes.
    initial begin
        forever begin
            @(negedge clk);
            n_tests++;
            if (evt_valid !== m_valid) begin
                n_fail++;
                $display("FAIL cyc_valid: got %0b expected %0b at %0t", evt_valid, m_valid, $time);
            end
            n_tests++;
            if (int'(evt_id) !== m_id) begin
                n_fail++;
                $display("FAIL cyc_id: got %0d expected %0d at %0t", evt_id, m_id, $time);
            end
            n_tests++;
            if (overrun !== model_ovr_vec()) begin
                n_fail++;
                $display("FAIL cyc_overrun: got %b expected %b at %0t", overrun, model_ovr_vec(), $time);
            end
            if (!rst && evt_valid && evt_ready) dut_log.push_back(int'(evt_id));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name, input int exp [$]);
        chk({name, "_count"}, dut_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
            chk($sformatf("%s_ev%0d", name, i), dut_log[i], exp[i]);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [N-1:0] v);
        pb_pulse = v;
        step();
        pb_pulse = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pb_pulse = '0;
        evt_ready = 1'b0;
        overrun_clr = 1'b0;
        step(2);
        rst = 1'b0;
        step();
        dut_log.delete();
    endtask

    initial begin
        do_reset();
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_id", int'(evt_id), 0);
        chk("reset_overrun", int'(overrun), 0);

        // single press held off by a stalled consumer
        pulse(4'b0100);
        step();
        chk("t1_valid", int'(evt_valid), 1);
        chk("t1_id", int'(evt_id), 2);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t1_hold_valid", int'(evt_valid), 1);
            chk("t1_hold_id", int'(evt_id), 2);
        end
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("t1_drained", int'(evt_valid), 0);

        // all buttons at once, back-to-back delivery
        do_reset();
        evt_ready = 1'b1;
        pulse(4'b1111);
        step(6);
        chk_log("t2", '{0, 1, 2, 3});
        chk("t2_valid", int'(evt_valid), 0);
        chk("t2_overrun", int'(overrun), 0);

        // fairness after the pointer wraps
        do_reset();
        evt_ready = 1'b1;
        pulse(4'b1000);
        step(4);
        pulse(4'b1010);
        step(4);
        pulse(4'b1001);
        step(4);
        chk_log("t3", '{3, 1, 3, 0, 3});

        // overrun: button 0 occupies the output, button 1 pressed twice
        do_reset();
        pulse(4'b0001);
        step();
        pulse(4'b0010);
        step(4);
        pulse(4'b0010);
        step();
        chk("t4_overrun", int'(overrun), 4'b0010);
        evt_ready = 1'b1;
        step(5);
        chk_log("t4", '{0, 1});
        chk("t4_overrun_sticky", int'(overrun), 4'b0010);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("t4_overrun_clr", int'(overrun), 0);

        // same-bit collision: re-press on the grant cycle is a new event
        do_reset();
        evt_ready = 1'b1;
        pb_pulse = 4'b0001;
        step(2);
        pb_pulse = '0;
        step(4);
        chk_log("t5", '{0, 0});
        chk("t5_overrun", int'(overrun), 0);

        // reset while an event is presented and three are pending
        do_reset();
        pulse(4'b0100);
        step();
        pulse(4'b1011);
        chk("t6_pre_valid", int'(evt_valid), 1);
        chk("t6_pre_id", int'(evt_id), 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", int'(evt_valid), 0);
        chk("t6_rst_id", int'(evt_id), 0);
        chk("t6_rst_overrun", int'(overrun), 0);
        step();
        rst = 1'b0;
        evt_ready = 1'b1;
        dut_log.delete();
        step(6);
        chk("t6_no_events", dut_log.size(), 0);
        chk("t6_idle_valid", int'(evt_valid), 0);
        pulse(4'b0001);
        step(3);
        chk_log("t6_after", '{0});

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
